// File: rtl/leg_mem_pkg.sv
// rtl/leg_mem_pkg.sv - shared types and helpers for the LEG data-memory access path
package leg_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } mau_state_t;

    localparam int BYTE_OFF_W = 3;

    // Right-aligned mask covering one access of the given size
    function automatic logic [63:0] lane_mask(mem_size_t size);
        logic [63:0] mask;
        case (size)
            SIZE_B:  mask = 64'h0000_0000_0000_00FF;
            SIZE_H:  mask = 64'h0000_0000_0000_FFFF;
            SIZE_W:  mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

    // An access is misaligned when its byte offset is not a multiple of its size
    function automatic logic is_misaligned(logic [BYTE_OFF_W-1:0] off, mem_size_t size);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = |off[1:0];
            default: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - doubleword lane extract with sign/zero extension, and lane merge
module mem_lane_align
    import leg_mem_pkg::*;
(
    input  logic [63:0]           rd_word,
    input  logic [63:0]           wr_lane,
    input  logic [BYTE_OFF_W-1:0] off,
    input  mem_size_t             size,
    input  logic                  sign_ext,
    output logic [63:0]           load_data,
    output logic [63:0]           merge_data
);

    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] mask;

    // Shift the addressed lane down, extend it, and build the merged store word
    always_comb begin
        shamt = {off, 3'b000};
        lane  = rd_word >> shamt;
        mask  = lane_mask(size);
        case (size)
            SIZE_B:  load_data = sign_ext ? {{56{lane[7]}},  lane[7:0]}  : {56'd0, lane[7:0]};
            SIZE_H:  load_data = sign_ext ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
            SIZE_W:  load_data = sign_ext ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
            default: load_data = lane;
        endcase
        merge_data = (rd_word & ~(mask << shamt)) | ((wr_lane & mask) << shamt);
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte-addressed load/store unit driving a 64-bit synchronous data RAM
module mem_access_unit
    import leg_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_WIDTH+2:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_writeData,
    input  logic [DATA_WIDTH-1:0]   mem_readData
);

    mau_state_t            state;
    logic                  ready_q;
    logic [BYTE_OFF_W-1:0] off_q;
    mem_size_t             size_q;
    logic                  signed_q;
    logic                  write_q;
    logic [63:0]           wdata_q;
    logic [63:0]           load_data;
    logic [63:0]           merge_data;
    mem_size_t             req_size_e;

    assign req_size_e = mem_size_t'(req_size);

    // Gate with rst_n so the core never sees ready during reset, even before the first reset edge
    assign req_ready = ready_q && rst_n;
    // Gate with rst_n so a reset landing on the WRITE cycle suppresses the RAM write edge
    assign mem_write = (state == ST_WRITE) && rst_n;

    mem_lane_align u_align (
        .rd_word    (mem_readData),
        .wr_lane    (wdata_q),
        .off        (off_q),
        .size       (size_q),
        .sign_ext   (signed_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Request sequencing FSM with registered response and RAM-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ready_q       <= 1'b0;
            off_q         <= '0;
            size_q        <= SIZE_B;
            signed_q      <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            mem_address   <= '0;
            mem_writeData <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_error    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        ready_q    <= 1'b0;
                        off_q      <= req_addr[BYTE_OFF_W-1:0];
                        size_q     <= req_size_e;
                        signed_q   <= req_signed;
                        write_q    <= req_write;
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        resp_error <= 1'b0;
                        if (is_misaligned(req_addr[BYTE_OFF_W-1:0], req_size_e)) begin
                            // Misaligned: answer immediately, leave the RAM port untouched
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            mem_address <= req_addr[ADDR_WIDTH+2:BYTE_OFF_W];
                            if (req_write && (req_size_e == SIZE_D)) begin
                                mem_writeData <= req_wdata;
                                state         <= ST_WRITE;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_MERGE;
                end
                ST_MERGE: begin
                    if (write_q) begin
                        mem_writeData <= merge_data;
                        state         <= ST_WRITE;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                    ready_q    <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit against a behavioural RAM
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [14:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic        mem_write;
    logic [11:0] mem_address;
    logic [63:0] mem_writeData;
    logic [63:0] mem_readData;

    logic [63:0] ram [0:4095];

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(12)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData)
    );

    always @(posedge clk) begin
        if (mem_write) ram[mem_address] <= mem_writeData;
        mem_readData <= ram[mem_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expected entry
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_error", {63'd0, resp_error}, {63'd0, e.err});
            end
        end
    end

    // Issue one request from a negedge; checks latency, write count/cycle and write address
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [14:0] a, input logic [63:0] wd,
                          input logic [63:0] er, input logic ee,
                          input int lat, input int wr_cyc);
        int t;
        int got_lat;
        int nwr;
        int wcyc;
        t = 0; got_lat = -1; nwr = 0; wcyc = -1;
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (req_ready !== 1'b1) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        sb.push_back('{er, ee});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_write === 1'b1) begin
                nwr++;
                wcyc = k;
                check("wr_addr", {52'd0, mem_address}, {52'd0, a[14:3]});
            end
            if (resp_valid === 1'b1) begin
                got_lat = k;
                break;
            end
        end
        check("resp_latency", 64'(got_lat), 64'(lat));
        check("write_count", 64'(nwr), (wr_cyc < 0) ? 64'd0 : 64'd1);
        check("write_cycle", 64'(wcyc), 64'(wr_cyc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k2;
        for (int i = 0; i < 4096; i++) ram[i] = 64'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",   {63'd0, req_ready},  64'd0);
        check("rst_mem_write",   {63'd0, mem_write},  64'd0);
        check("rst_mem_address", {52'd0, mem_address}, 64'd0);
        check("rst_mem_wdata",   mem_writeData,       64'd0);
        check("rst_resp_valid",  {63'd0, resp_valid}, 64'd0);
        check("rst_resp_rdata",  resp_rdata,          64'd0);
        check("rst_resp_error",  {63'd0, resp_error}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {63'd0, req_ready}, 64'd1);

        // write, size, signed, addr, wdata, exp rdata, exp err, latency, write cycle
        do_req(1, 2'd3, 0, 15'h010, 64'h0123456789ABCDEF, 64'd0, 0, 2, 1);
        do_req(0, 2'd3, 0, 15'h010, 64'd0, 64'h0123456789ABCDEF, 0, 3, -1);
        do_req(1, 2'd0, 0, 15'h013, 64'h00000000000000AA, 64'd0, 0, 4, 3);
        do_req(0, 2'd3, 0, 15'h010, 64'd0, 64'h01234567AAABCDEF, 0, 3, -1);
        do_req(0, 2'd0, 1, 15'h013, 64'd0, 64'hFFFFFFFFFFFFFFAA, 0, 3, -1);
        do_req(0, 2'd0, 0, 15'h013, 64'd0, 64'h00000000000000AA, 0, 3, -1);
        do_req(0, 2'd1, 1, 15'h016, 64'd0, 64'h0000000000000123, 0, 3, -1);
        do_req(0, 2'd2, 0, 15'h012, 64'd0, 64'd0, 1, 1, -1);
        do_req(1, 2'd3, 0, 15'h011, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1, 1, -1);

        // Back-to-back loads with req_valid held high
        req_write = 0; req_size = 2'd3; req_signed = 0; req_addr = 15'h010; req_valid = 1'b1;
        k2 = 0;
        while (req_ready !== 1'b1 && k2 < 50) begin @(negedge clk); k2++; end
        check("b2b_first_accept", {63'd0, req_ready}, 64'd1);
        sb.push_back('{64'h01234567AAABCDEF, 1'b0});
        @(posedge clk);
        #1 req_size = 2'd0; req_addr = 15'h010;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("b2b_ready_busy", {63'd0, req_ready}, 64'd0);
        end
        @(negedge clk);
        check("b2b_ready_n4", {63'd0, req_ready}, 64'd1);
        sb.push_back('{64'h00000000000000EF, 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        k2 = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin k2 = k; break; end
        end
        check("b2b_second_latency", 64'(k2), 64'd3);

        // Reset during the WRITE cycle of a byte store
        @(negedge clk);
        req_write = 1; req_size = 2'd0; req_signed = 0; req_addr = 15'h010;
        req_wdata = 64'h55; req_valid = 1'b1;
        k2 = 0;
        while (req_ready !== 1'b1 && k2 < 50) begin @(negedge clk); k2++; end
        check("abort_accept", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_write", {63'd0, mem_write}, 64'd1);
        rst_n = 1'b0;
        #1 check("abort_write_gated", {63'd0, mem_write}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after", {63'd0, req_ready}, 64'd1);
        do_req(0, 2'd3, 0, 15'h010, 64'd0, 64'h01234567AAABCDEF, 0, 3, -1);

        do_req(1, 2'd2, 0, 15'h014, 64'h00000000CAFEF00D, 64'd0, 0, 4, 3);
        do_req(0, 2'd2, 1, 15'h014, 64'd0, 64'hFFFFFFFFCAFEF00D, 0, 3, -1);
        do_req(0, 2'd3, 0, 15'h010, 64'd0, 64'hCAFEF00DAAABCDEF, 0, 3, -1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side data-memory access unit for the LEG CPU: it sits between the execute/memory stage and the single-port data RAM and drives that RAM's clock-synchronous port. It converts byte-addressed load/store requests of size byte, half, word or dword into RAM doubleword transactions. Sub-doubleword stores are done as read-modify-write, and loads are lane-extracted with optional sign extension. The core issues one request at a time and stalls on `req_ready` low.

## Interface
- `DATA_WIDTH`, 64: RAM word width; fixed at 64.
- `ADDR_WIDTH`, 12: RAM word-address width; byte address is `ADDR_WIDTH+3` bits.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset; synchronous and active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit idle; request accepted on `req_valid && req_ready` at a rising edge.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `req_signed`  in  1: sign-extend load result; ignored for stores.
- `req_addr`  in  `ADDR_WIDTH+3`: byte address, little-endian.
- `req_wdata`  in  64: store data, right-aligned.
- `resp_valid`  out  1: one-cycle completion pulse; no backpressure.
- `resp_rdata`  out  64: load result; 0 for stores and errors.
- `resp_error`  out  1: misaligned request; valid with `resp_valid`.
- `mem_write`  out  1: RAM write enable.
- `mem_address`  out  `ADDR_WIDTH`: RAM word address, equal to `req_addr[ADDR_WIDTH+2:3]`.
- `mem_writeData`  out  64: RAM write data.
- `mem_readData`  in  64: RAM read data, valid the cycle after the address is presented.

## Operation
- **FSM states:** IDLE, READ, MERGE, WRITE, RESP.
- **Accept:** in IDLE, on accept, latch addr, size, signed, write and wdata.
- **Alignment check:** a request is misaligned when `req_addr` is not a multiple of `1<<req_size`. Misaligned requests go to RESP with `resp_error=1` and never touch the RAM.
- **Load path:** IDLE → READ → MERGE → RESP.
  - In MERGE, take lane `off=addr[2:0]` at bit `8*off` with width `8<<size`.
  - Zero- or sign-extend that lane to 64 bits and register it into `resp_rdata`.
- **Dword store:** IDLE → WRITE → RESP. In WRITE, `mem_writeData = wdata`.
- **Sub-dword store:** IDLE → READ → MERGE → WRITE → RESP.
  - In MERGE, replace lane `off` of `mem_readData` with the low `8<<size` bits of wdata and register the result.
  - In WRITE, write the merged value.
- **RESP:** `resp_valid=1` for exactly one cycle, then return to IDLE.
- **Registered outputs:** `mem_address` is registered at accept and held until IDLE.
- **Write enable:** `mem_write = (state==WRITE) && rst_n`, so no write occurs in a cycle where reset is asserted.
- **Read/write overlap:** the unit never reads and writes in the same cycle, so RAM read-during-write ordering does not matter.

## Timing
Accept edge is at the end of cycle N.
- **Load:** READ in N+1, data sampled in N+2, `resp_valid` in N+3.
- **Dword store:** RAM write at the end of N+1, `resp_valid` in N+2.
- **Sub-dword store:** RAM write at the end of N+3, `resp_valid` in N+4.
- **Error:** `resp_valid` with `resp_error=1` in N+1.
- **Throughput:** `req_ready=1` only in IDLE. The next accept is earliest in the cycle after RESP, so there is no same-cycle response/accept.
- **Reset values:** state IDLE; `req_ready=0` while `rst_n=0`, 1 from the first cycle after. `mem_write=0`, `mem_address=0`, `mem_writeData=0`, `resp_valid=0`, `resp_rdata=0`, `resp_error=0`.
- **Reset mid-operation:** abort with no response, no write and no partial merge. The RAM keeps its prior contents unless the write edge has already occurred.
- `req_*` inputs are ignored when `req_ready=0`.

## Structure
- **Package `leg_mem_pkg`:**
  - `mem_size_t` enum (SIZE_B, SIZE_H, SIZE_W, SIZE_D);
  - `mau_state_t` enum;
  - constant `BYTE_OFF_W=3`.
- **Sub-module `mem_lane_align`:** combinational; does lane extract plus sign/zero extension, and lane merge. It is reused later by the instruction-fetch path.

## Test plan
- Reset, then store dword `0x0123456789ABCDEF` to `0x010`, then load dword from `0x010` → `mem_write` pulses once at N+1. Load gives `resp_rdata=0x0123456789ABCDEF` with `resp_valid` at N+3.
- Store byte `0xAA` to `0x013`, then load dword from `0x010` → `0x01234567AAABCDEF`. Exactly one RAM write, at N+3; `resp_valid` at N+4.
- Load byte from `0x013` with `req_signed=1` → `0xFFFFFFFFFFFFFFAA`. With `req_signed=0` → `0x00000000000000AA`. Load half from `0x016` signed → `0x0000000000000123`.
- Load word from `0x012` → `resp_valid` and `resp_error=1` at N+1, `resp_rdata=0`, `mem_write` never asserted.
- Start a byte store, drive `rst_n=0` in the WRITE cycle → `mem_write=0`, and a later load shows the RAM unchanged. `req_ready=1` in the first cycle after `rst_n` returns high, and no `resp_valid` is seen.
- Hold `req_valid=1` across two back-to-back loads → `req_ready=0` in N+1..N+3, and the second load is accepted at the end of N+4.
